// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported memory with a 1-cycle synchronous read between the
//   instruction-fetch (IF) and load/store (LS) requesters. LS has fixed priority,
//   but a starvation counter forces an IF grant after STARVE_LIMIT consecutive
//   denied IF cycles (STARVE_LIMIT = 0 gives strict LS priority). Read responses
//   are steered back to the requester that issued them, one cycle after grant.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   if_req/if_addr               IF read request (held until if_gnt)
//   if_gnt/if_rvalid/if_rdata    IF grant (combinational), read response
//   ls_req/ls_we/ls_addr/
//   ls_wdata/ls_size             LS request (held until ls_gnt)
//   ls_gnt/ls_rvalid/ls_rdata    LS grant (combinational), read response
//   mem_en/mem_we/mem_addr/
//   mem_wdata/mem_size           memory command, muxed from the winner
//   mem_rdata                    memory read data, one cycle after a read
//
// Configuration macro
//   ARB_STATS_EN  adds stat_if_gnt, stat_ls_gnt, stat_conflict (32-bit,
//                 wrapping, cleared on rst) counting IF grants, LS grants and
//                 cycles in which both requesters are active.

module mem_port_arbiter #(
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [AW-1:0] ls_addr,
  input  logic [DW-1:0] ls_wdata,
  input  logic [1:0]    ls_size,
  output logic          ls_gnt,
  output logic          ls_rvalid,
  output logic [DW-1:0] ls_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [1:0]    mem_size,
  input  logic [DW-1:0] mem_rdata
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]   stat_if_gnt,
  output logic [31:0]   stat_ls_gnt,
  output logic [31:0]   stat_conflict
`endif
);

  // A zero limit still needs a 1-bit counter to keep widths legal; it never counts.
  localparam int unsigned CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] r_starve_cnt;
  logic [1:0]    r_owner;       // [1] = IF read in flight, [0] = LS read in flight
  logic          w_force_if;
  logic          w_if_gnt;
  logic          w_ls_gnt;

  always_comb begin
    w_force_if = (STARVE_LIMIT != 0) && (r_starve_cnt == LIMIT);
    w_if_gnt   = !rst && if_req && (!ls_req || w_force_if);
    w_ls_gnt   = !rst && ls_req && !w_if_gnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (!if_req || w_if_gnt) begin
      r_starve_cnt <= '0;
    end else if (r_starve_cnt != LIMIT) begin
      r_starve_cnt <= r_starve_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner <= '0;
    end else begin
      r_owner <= {w_if_gnt, w_ls_gnt && !ls_we};
    end
  end

  always_comb begin
    if_gnt    = w_if_gnt;
    ls_gnt    = w_ls_gnt;
    mem_en    = w_if_gnt | w_ls_gnt;
    mem_we    = w_ls_gnt & ls_we;
    mem_addr  = w_ls_gnt ? ls_addr : if_addr;
    mem_wdata = ls_wdata;
    mem_size  = w_ls_gnt ? ls_size : 2'd2;
    // Masked during reset so a response launched just before rst is dropped.
    if_rvalid = r_owner[1] && !rst;
    ls_rvalid = r_owner[0] && !rst;
    if_rdata  = mem_rdata;
    ls_rdata  = mem_rdata;
  end

`ifdef ARB_STATS_EN
  logic [31:0] r_stat_if_gnt;
  logic [31:0] r_stat_ls_gnt;
  logic [31:0] r_stat_conflict;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_if_gnt   <= '0;
      r_stat_ls_gnt   <= '0;
      r_stat_conflict <= '0;
    end else begin
      if (w_if_gnt)          r_stat_if_gnt   <= r_stat_if_gnt + 32'd1;
      if (w_ls_gnt)          r_stat_ls_gnt   <= r_stat_ls_gnt + 32'd1;
      if (if_req && ls_req)  r_stat_conflict <= r_stat_conflict + 32'd1;
    end
  end

  always_comb begin
    stat_if_gnt   = r_stat_if_gnt;
    stat_ls_gnt   = r_stat_ls_gnt;
    stat_conflict = r_stat_conflict;
  end
`endif

endmodule
